// File: rtl/pc_stack_unit.sv
// Program counter with conditional jump, relative branch and CALL/RET.
// Return addresses live in a small LIFO with sticky overflow/underflow flag.
module pc_stack_unit #(
    parameter int ADDR_W     = 10,
    parameter int DISP_W     = 8,
    parameter int DEPTH      = 8,
    parameter int SP_W       = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [2:0]        pc_op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DISP_W-1:0] disp,
    output logic [ADDR_W-1:0] pc_out,
    output logic [SP_W-1:0]   sp_depth,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDR);
    localparam logic [SP_W-1:0]   SP_MAX = SP_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic [ADDR_W-1:0] disp_ext;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] top;
    logic [SP_W-1:0]   sp_m1;
    logic              full, empty;
    logic              push;

    // Displacement sign-extended (or truncated) to the PC width.
    if (DISP_W >= ADDR_W) begin : g_trunc
        assign disp_ext = disp[ADDR_W-1:0];
    end else begin : g_sext
        assign disp_ext = {{(ADDR_W - DISP_W){disp[DISP_W-1]}}, disp};
    end

    assign pc_inc = pc_q + ADDR_W'(1);
    assign sp_m1  = sp_q - SP_W'(1);
    assign full   = (sp_q == SP_MAX);
    assign empty  = (sp_q == '0);

    // Read the top-of-stack entry selected by the depth counter.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_m1 == SP_W'(i)) top = stack_q[i];
        end
    end

    // Next-state decode for PC, depth and error flag.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (pc_en) begin
            case (pc_op)
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   pc_d = cond ? pc_in : pc_inc;
                OP_BRANCH: pc_d = cond ? pc_q + disp_ext : pc_inc;
                OP_CALL: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        pc_d = pc_in;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d = sp_m1;
                        pc_d = top;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RST_PC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; contents need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && push && sp_q == SP_W'(i)) stack_q[i] <= pc_inc;
        end
    end

    assign pc_out      = pc_q;
    assign sp_depth    = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios plus random ops
// compared against a queue-based behavioural model.
module tb_pc_stack_unit;

    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int SW  = 4;
    localparam int RA  = 0;

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BRA = 3'd2;
    localparam logic [2:0] CAL = 3'd3, RET = 3'd4, HLD = 3'd5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pc_en = 1'b0;
    logic [2:0]    pc_op = '0;
    logic          cond = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic [DW-1:0] disp = '0;
    logic [AW-1:0] pc_out;
    logic [SW-1:0] sp_depth;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_err;

    pc_stack_unit #(
        .ADDR_W(AW), .DISP_W(DW), .DEPTH(DEP), .SP_W(SW), .RESET_ADDR(RA)
    ) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .pc_op(pc_op),
        .cond(cond), .pc_in(pc_in), .disp(disp), .pc_out(pc_out),
        .sp_depth(sp_depth), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int m_pc = 0;
    int m_stk[$];
    bit m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        if (obs !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour applied at each sampled edge.
    task automatic model_step();
        int d;
        if (reset) begin
            m_pc = RA;
            m_stk.delete();
            m_err = 0;
        end else if (pc_en) begin
            if (pc_op == INC) begin
                m_pc = (m_pc + 1) % 1024;
            end else if (pc_op == JMP) begin
                m_pc = cond ? int'(pc_in) : (m_pc + 1) % 1024;
            end else if (pc_op == BRA) begin
                d = (disp >= 128) ? int'(disp) - 256 : int'(disp);
                m_pc = cond ? (m_pc + d + 1024) % 1024 : (m_pc + 1) % 1024;
            end else if (pc_op == CAL) begin
                if (m_stk.size() == DEP) m_err = 1;
                else begin
                    m_stk.push_back((m_pc + 1) % 1024);
                    m_pc = int'(pc_in);
                end
            end else if (pc_op == RET) begin
                if (m_stk.size() == 0) m_err = 1;
                else m_pc = m_stk.pop_back();
            end
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [2:0] op,
                        input logic c, input logic [AW-1:0] tgt,
                        input logic [DW-1:0] d);
        reset = r;
        pc_en = en;
        pc_op = op;
        cond  = c;
        pc_in = tgt;
        disp  = d;
        @(posedge clk);
        model_step();
        #1;
        check("pc_out", pc_out, m_pc);
        check("sp_depth", sp_depth, m_stk.size());
        check("full", stack_full, int'(m_stk.size() == DEP));
        check("empty", stack_empty, int'(m_stk.size() == 0));
        check("err", stack_err, int'(m_err));
    endtask

    initial begin
        int k;
        logic [2:0] op;

        step(1, 0, INC, 0, 0, 0);
        check("rst_pc", pc_out, 0);
        check("rst_empty", stack_empty, 1);
        repeat (3) step(0, 1, INC, 0, 0, 0);
        check("inc3", pc_out, 3);
        repeat (2) step(0, 0, INC, 0, 0, 0);
        check("hold_en0", pc_out, 3);

        step(0, 1, JMP, 1, 10'h010, 0);
        step(0, 1, JMP, 0, 10'h200, 0);
        check("jmp_nt", pc_out, 'h011);
        step(0, 1, JMP, 1, 10'h200, 0);
        check("jmp_t", pc_out, 'h200);
        step(0, 1, BRA, 1, 0, 8'hFC);
        check("br_neg", pc_out, 'h1FC);
        step(0, 1, BRA, 1, 0, 8'h00);
        check("br_self", pc_out, 'h1FC);
        step(0, 1, BRA, 0, 0, 8'h40);
        check("br_nt", pc_out, 'h1FD);

        step(0, 1, JMP, 1, 10'h3FF, 0);
        step(0, 1, INC, 0, 0, 0);
        check("inc_wrap", pc_out, 0);
        step(0, 1, BRA, 1, 0, 8'hFE);
        check("br_wrap", pc_out, 'h3FE);
        step(0, 1, JMP, 1, 10'h3FF, 0);
        step(0, 1, CAL, 0, 10'h050, 0);
        check("call_wrap", pc_out, 'h050);
        step(0, 1, RET, 0, 0, 0);
        check("ret_wrap", pc_out, 0);

        step(0, 1, JMP, 1, 10'h100, 0);
        step(0, 1, CAL, 1, 10'h200, 0);
        step(0, 1, CAL, 0, 10'h300, 0);
        step(0, 1, CAL, 1, 10'h040, 0);
        step(0, 1, CAL, 0, 10'h080, 0);
        check("nest_full", stack_full, 1);
        check("nest_sp", sp_depth, 4);
        check("nest_err", stack_err, 0);
        step(0, 1, RET, 0, 0, 0);
        check("ret1", pc_out, 'h041);
        step(0, 1, RET, 0, 0, 0);
        check("ret2", pc_out, 'h301);
        step(0, 1, RET, 0, 0, 0);
        check("ret3", pc_out, 'h201);
        step(0, 1, RET, 0, 0, 0);
        check("ret4", pc_out, 'h101);
        check("drained", stack_empty, 1);

        for (int i = 0; i < 4; i++) step(0, 1, CAL, 0, AW'(i * 16), 0);
        step(0, 1, CAL, 0, 10'h123, 0);
        check("ovf_pc", pc_out, 'h030);
        check("ovf_sp", sp_depth, 4);
        check("ovf_err", stack_err, 1);
        repeat (4) step(0, 1, RET, 0, 0, 0);
        check("drain_pc", pc_out, 'h102);
        step(0, 1, RET, 0, 0, 0);
        check("udf_pc", pc_out, 'h102);
        check("udf_err", stack_err, 1);
        step(0, 1, INC, 0, 0, 0);
        check("inc_after_err", pc_out, 'h103);

        step(0, 1, CAL, 0, 10'h111, 0);
        step(0, 1, CAL, 0, 10'h222, 0);
        check("pre_rst_sp", sp_depth, 2);
        step(1, 1, CAL, 0, 10'h333, 0);
        check("rst_mid_pc", pc_out, RA);
        check("rst_mid_sp", sp_depth, 0);
        check("rst_mid_err", stack_err, 0);
        step(0, 1, RET, 0, 0, 0);
        check("rst_then_udf", stack_err, 1);

        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2) op = INC;
            else if (k == 2) op = JMP;
            else if (k == 3) op = BRA;
            else if (k < 6) op = CAL;
            else if (k < 8) op = RET;
            else op = 3'($urandom_range(5, 7));
            step($urandom_range(0, 79) == 0, $urandom_range(0, 7) != 0, op,
                 1'($urandom), AW'($urandom), DW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
